// File: rtl/ldm_writeback_sequencer_pkg.sv
// Shared definitions for the LDM writeback sequencer: FSM state encoding,
// register-list width, PC register index and default address step.
package ldm_writeback_sequencer_pkg;

    localparam int         REG_LIST_W = 16;
    localparam int         ADDR_STEP  = 4;
    localparam logic [3:0] PC_INDEX   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WRITE = 3'd2,
        ST_WBACK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ldm_writeback_sequencer_reg_list_prienc.sv
// Lowest-set-bit priority encoder for a 16-bit register list.
// Ports: list (in, 16) -> idx (out, 4, lowest set bit), any (out, list != 0).
module reg_list_prienc
    import ldm_writeback_sequencer_pkg::*;
(
    input  logic [REG_LIST_W-1:0] list,
    output logic [3:0]            idx,
    output logic                  any
);

    // Scanning downwards leaves the lowest set index as the final value.
    always_comb begin
        idx = 4'd0;
        for (int i = REG_LIST_W - 1; i >= 0; i--) begin
            if (list[i]) begin
                idx = i[3:0];
            end
        end
    end

    assign any = |list;

endmodule

// File: rtl/ldm_writeback_sequencer.sv
// LDM-style multi-register load sequencer driving the register-file write side.
// Ports: Clk, R (sync reset), start/reg_list/base_addr/rn/wback (command),
//        mem_req/mem_addr/mem_data/mem_valid (read port),
//        PW/RW/load (R0-R14 write), pc_in/pc_enable (R15 write), busy, done.
module ldm_writeback_sequencer
    import ldm_writeback_sequencer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_STEP = ldm_writeback_sequencer_pkg::ADDR_STEP
) (
    input  logic                  Clk,
    input  logic                  R,
    input  logic                  start,
    input  logic [REG_LIST_W-1:0] reg_list,
    input  logic [DATA_W-1:0]     base_addr,
    input  logic [3:0]            rn,
    input  logic                  wback,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_valid,
    output logic                  mem_req,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     PW,
    output logic [3:0]            RW,
    output logic                  load,
    output logic [DATA_W-1:0]     pc_in,
    output logic                  pc_enable,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(ADDR_STEP);

    state_t                  state;
    logic [REG_LIST_W-1:0]   list_reg;
    logic [REG_LIST_W-1:0]   orig_list;
    logic [DATA_W-1:0]       addr_reg;
    logic [DATA_W-1:0]       data_reg;
    logic [3:0]              rn_reg;
    logic                    wback_reg;

    logic [REG_LIST_W-1:0]   pe_in;
    logic [3:0]              pe_idx;
    logic                    pe_any;
    logic [REG_LIST_W-1:0]   rem_list;

    // One encoder serves both the IDLE empty-list check (fresh command)
    // and the WRITE target selection (latched list).
    assign pe_in    = (state == ST_IDLE) ? reg_list : list_reg;
    assign rem_list = list_reg & ~(REG_LIST_W'(1) << pe_idx);

    reg_list_prienc u_prienc (
        .list (pe_in),
        .idx  (pe_idx),
        .any  (pe_any)
    );

    always_ff @(posedge Clk) begin
        if (R) begin
            state     <= ST_IDLE;
            list_reg  <= '0;
            orig_list <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            rn_reg    <= '0;
            wback_reg <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        list_reg  <= reg_list;
                        orig_list <= reg_list;
                        addr_reg  <= base_addr;
                        rn_reg    <= rn;
                        wback_reg <= wback;
                        if (pe_any)     state <= ST_REQ;
                        else if (wback) state <= ST_WBACK;
                        else            state <= ST_DONE;
                    end
                end
                ST_REQ: begin
                    if (mem_valid) begin
                        data_reg <= mem_data;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    list_reg <= rem_list;
                    addr_reg <= addr_reg + STEP;
                    // A base register that is also loaded keeps the loaded value.
                    if (|rem_list)
                        state <= ST_REQ;
                    else if (wback_reg && !orig_list[rn_reg])
                        state <= ST_WBACK;
                    else
                        state <= ST_DONE;
                end
                ST_WBACK: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        PW        = '0;
        RW        = 4'd0;
        load      = 1'b0;
        pc_in     = '0;
        pc_enable = 1'b0;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        unique case (state)
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr_reg;
            end
            ST_WRITE: begin
                if (pe_idx == PC_INDEX) begin
                    pc_enable = 1'b1;
                    pc_in     = data_reg;
                end else begin
                    load = 1'b1;
                    RW   = pe_idx;
                    PW   = data_reg;
                end
            end
            ST_WBACK: begin
                if (rn_reg == PC_INDEX) begin
                    pc_enable = 1'b1;
                    pc_in     = addr_reg;
                end else begin
                    load = 1'b1;
                    RW   = rn_reg;
                    PW   = addr_reg;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_writeback_sequencer.sv
// Self-checking bench for ldm_writeback_sequencer: directed and random
// transfers checked against a queue of expected register-file writes.
module tb_ldm_writeback_sequencer;

    logic        Clk = 1'b0;
    logic        R;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic [3:0]  rn;
    logic        wback;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] PW;
    logic [3:0]  RW;
    logic        load;
    logic [31:0] pc_in;
    logic        pc_enable;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pc;
        logic [3:0]  idx;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    always #5 Clk = ~Clk;

    ldm_writeback_sequencer #(.DATA_W(32), .ADDR_STEP(4)) dut (
        .Clk       (Clk),
        .R         (R),
        .start     (start),
        .reg_list  (reg_list),
        .base_addr (base_addr),
        .rn        (rn),
        .wback     (wback),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .PW        (PW),
        .RW        (RW),
        .load      (load),
        .pc_in     (pc_in),
        .pc_enable (pc_enable),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign mem_data = memf(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_mem_req"}, 32'(mem_req), 0);
        chk({p, "_mem_addr"}, mem_addr, 0);
        chk({p, "_PW"}, PW, 0);
        chk({p, "_RW"}, 32'(RW), 0);
        chk({p, "_load"}, 32'(load), 0);
        chk({p, "_pc_in"}, pc_in, 0);
        chk({p, "_pc_enable"}, 32'(pc_enable), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_done"}, 32'(done), 0);
    endtask

    // mode 0: mem_valid tied high (latency checked)
    // mode 1: random mem_valid
    // mode 2: 3-cycle read latency plus stray mem_valid pulses outside REQ
    task automatic run_txn(input logic [15:0] l, input logic [31:0] b,
                           input logic [3:0] r, input logic w,
                           input int mode);
        wr_t q[$];
        wr_t e;
        int  n = 0;
        int  nw = 0;
        int  nr = 0;
        int  exp_done;
        int  wait_cnt = 0;
        bit  wb_taken;
        bit  finished = 0;
        for (int k = 0; k < 16; k++) begin
            if (l[k]) begin
                e.pc   = (k == 15);
                e.idx  = 4'(k);
                e.addr = b + 32'(4 * n);
                e.data = memf(e.addr);
                q.push_back(e);
                n++;
            end
        end
        wb_taken = w && !l[r];
        if (wb_taken) begin
            e.pc   = (r == 4'd15);
            e.idx  = r;
            e.addr = b + 32'(4 * n);
            e.data = e.addr;
            q.push_back(e);
        end
        if (n == 0) exp_done = wb_taken ? 2 : 1;
        else        exp_done = 2 * n + (wb_taken ? 1 : 0) + 1;

        @(negedge Clk);
        reg_list  = l;
        base_addr = b;
        rn        = r;
        wback     = w;
        start     = 1'b1;
        mem_valid = 1'b0;
        @(posedge Clk);
        #1;
        start     = 1'b0;
        reg_list  = 16'($urandom);
        base_addr = $urandom;
        rn        = 4'($urandom);
        wback     = 1'($urandom);

        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(negedge Clk);
            chk("ld_pc_excl", 32'(load & pc_enable), 0);
            if (mem_req) begin
                chk("req_pending", 32'(nr < n), 1);
                chk("mem_addr", mem_addr, b + 32'(4 * nr));
            end
            if (load | pc_enable) begin
                if (q.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("wr_kind", 32'(pc_enable), 32'(e.pc));
                    if (e.pc) begin
                        chk("pc_in", pc_in, e.data);
                    end else begin
                        chk("RW", 32'(RW), 32'(e.idx));
                        chk("PW", PW, e.data);
                    end
                    if (mode == 0)
                        chk("wr_cycle", cyc,
                            (nw < n) ? 2 * (nw + 1) : 2 * n + 1);
                    if (nw < n) nr++;
                    nw++;
                end
            end
            if (done) begin
                chk("done_q_empty", q.size(), 0);
                if (mode == 0) chk("done_cycle", cyc, exp_done);
                chk("done_busy", 32'(busy), 1);
                mem_valid = 1'b0;
                @(negedge Clk);
                chk("post_busy", 32'(busy), 0);
                chk("post_done", 32'(done), 0);
                finished = 1;
            end else begin
                chk("busy", 32'(busy), 1);
                case (mode)
                    0: mem_valid = 1'b1;
                    1: mem_valid = 1'($urandom_range(0, 1));
                    default: begin
                        if (mem_req) begin
                            wait_cnt++;
                            mem_valid = (wait_cnt >= 3);
                            if (mem_valid) wait_cnt = 0;
                        end else begin
                            wait_cnt  = 0;
                            mem_valid = 1'b1;
                        end
                    end
                endcase
            end
        end
        if (!finished) chk("timeout", 0, 1);
        mem_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] l;
        R         = 1'b1;
        start     = 1'b0;
        reg_list  = '0;
        base_addr = '0;
        rn        = '0;
        wback     = 1'b0;
        mem_valid = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk_idle("reset");
        R = 1'b0;

        run_txn(16'h0005, 32'h0000_0100, 4'd0, 1'b0, 0);
        run_txn(16'h8002, 32'h0000_0200, 4'd4, 1'b1, 0);
        run_txn(16'h0010, 32'h0000_0040, 4'd4, 1'b1, 0);
        run_txn(16'h0003, 32'h0000_0500, 4'd0, 1'b0, 2);
        run_txn(16'h0000, 32'h0000_0300, 4'd2, 1'b1, 0);
        run_txn(16'h0000, 32'h0000_0300, 4'd2, 1'b0, 0);
        run_txn(16'h0000, 32'h0000_0600, 4'd15, 1'b1, 0);
        run_txn(16'hFFFF, 32'hFFFF_FFF8, 4'd3, 1'b1, 0);
        run_txn(16'h4001, 32'hFFFF_FFFC, 4'd15, 1'b1, 1);

        // Abort in REQ of the second transfer.
        @(negedge Clk);
        reg_list  = 16'h0007;
        base_addr = 32'h0000_0400;
        rn        = 4'd0;
        wback     = 1'b1;
        start     = 1'b1;
        mem_valid = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        @(negedge Clk);
        chk("abort_c1_req", 32'(mem_req), 1);
        @(negedge Clk);
        chk("abort_c2_load", 32'(load), 1);
        chk("abort_c2_RW", 32'(RW), 0);
        @(negedge Clk);
        chk("abort_c3_req", 32'(mem_req), 1);
        chk("abort_c3_addr", mem_addr, 32'h0000_0404);
        R = 1'b1;
        @(negedge Clk);
        chk_idle("abort");
        R = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            chk("abort_load", 32'(load), 0);
            chk("abort_pc", 32'(pc_enable), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_busy", 32'(busy), 0);
        end
        mem_valid = 1'b0;
        run_txn(16'h0007, 32'h0000_0400, 4'd9, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            l = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 4) == 0) l = '0;
            run_txn(l, $urandom & 32'hFFFF_FFFC, 4'($urandom),
                    1'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
